alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single datapath ALU between several requesters, such as the integer pipeline and a multiply/shift coprocessor port. It arbitrates round-robin, translates the MIPS-style 6-bit funct into the 4-bit ALU control code, and drives the ALU operands. It waits a funct-dependent number of cycles, then returns the captured result over a valid/ready response channel. It sits between the requesters and the combinational ALU, which stays unchanged.

## Interface
- N, 16, operand/result width
- NREQ, 2, number of requesters (≥2)
- MUL_CYCLES, 3, ALU cycles a MUL (funct 6'b011000) needs before its result is sampled (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i]
- req_funct  in  6*NREQ  funct of requester i in bits [6i+5:6i]
- req_a, req_b  in  N*NREQ  operands of requester i in bits [Ni+N-1:Ni]
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  $clog2(NREQ)  index of the requester being answered
- resp_result  out  N  ALU result
- resp_err  out  1  illegal funct flag (see Configuration)
- alu_control  out  4  to ALU
- alu_a, alu_b  out  N  to ALU
- alu_result  in  N  from ALU, combinational on alu_control/alu_a/alu_b

## Operation
- FSM states are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE:
  - Search req_valid starting at priority pointer ptr, upward modulo NREQ. The first set bit wins.
  - req_ready is asserted combinationally for the winner only. It is all-zero outside IDLE or when no request is valid.
  - On grant: latch funct→alu_control, req_a/req_b→alu_a/alu_b, and winner→resp_id. Load cnt = (funct==MUL ? MUL_CYCLES : 1) − 1. Go to EXEC.
- Funct map:
  - AND 100100→0000, OR 100101→0001, ADD 100000→0010, SUB 100010→0110, SLT 101010→0111
  - NOR 100111→0011, MUL 011000→1001, SLL 000000→1010, SRL 000010→1101
  - XOR 100110→0100, SLTU 101011→1110, SRA 000011→1111
  - Any other funct→0010 (ADD).
- EXEC:
  - alu_* stay stable.
  - If cnt≠0, decrement cnt.
  - If cnt==0, register alu_result into resp_result and go to RESP.
- RESP:
  - resp_valid=1. resp_id, resp_result and resp_err are held stable until resp_valid & resp_ready.
  - On handshake: ptr ← (resp_id+1) mod NREQ, go to IDLE.
  - A new grant can occur in the cycle after the handshake, not in the same cycle.
- Reset values: state IDLE, ptr 0, resp_valid 0, resp_id 0, resp_result 0, resp_err 0, alu_control 4'b0010, alu_a 0, alu_b 0.
- Asserting rst in EXEC or RESP aborts the operation immediately. No response is ever issued for it.
- Requesters must hold req_* stable until granted. The arbiter never grants a requester whose req_valid is low.

## Timing
- Grant at edge T (IDLE, handshake).
- Non-MUL: resp_valid rises at T+2.
- MUL: resp_valid rises at T+1+MUL_CYCLES.
- Minimum spacing between grants is 3 cycles (non-MUL, resp_ready held high).
- req_ready is the only combinational path from an input (req_valid). All other outputs are registered.

## Configuration
- ALU_ARB_FUNCT_CHECK_EN defined:
  - A funct outside the table sets resp_err=1 and resp_result=0.
  - IDLE goes directly to RESP, skipping EXEC, so resp_valid rises at T+1.
  - alu_* are not updated.
- Not defined: unknown funct executes as ADD, and resp_err is tied 0.

## Structure
- Shared package alu_arb_pkg holds:
  - the state enum
  - the 4-bit ALU control code localparams
  - the funct localparams, including F_MUL
  - the funct→control decode function
- One sub-module, alu_rr_pick: combinational rotate-priority picker, taking (req_valid, ptr) and returning a one-hot grant plus an index.

## Test plan
- ADD: req0 funct 100000, a=3, b=5 → alu_control 0010, resp_valid at T+2, resp_result=8, resp_id=0.
- MUL with MUL_CYCLES=3: req1 funct 011000, a=0x0007, b=0x0006 → alu_control 1001, resp_valid at T+4, result 0x002A, resp_id=1.
- Both requesters valid continuously from reset (SUB 10−4 and OR 0x00F0|0x000F) → grant order 0,1,0,1. Results are 6 and 0x00FF.
- resp_ready low for 5 cycles in RESP → resp_* stable, req_ready all zero. Handshake on cycle 6, then the next grant one cycle later.
- Illegal funct 111111, a=2, b=2:
  - with ALU_ARB_FUNCT_CHECK_EN: resp_err=1, result 0 at T+1
  - without it: result 4, resp_err=0, at T+2
- rst pulsed mid-EXEC of a MUL → all outputs return to reset values, no resp_valid, ptr=0. The next request is served normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM states, ALU control codes,
// MIPS funct codes and the funct -> ALU control decode.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // 4-bit ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  // MIPS-style 6-bit funct codes
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SRA  = 6'b000011;

  // Unknown funct codes fall back to ADD.
  function automatic logic [3:0] funct_to_ctrl(input logic [5:0] funct);
    logic [3:0] ctrl;
    case (funct)
      F_AND:   ctrl = ALU_AND;
      F_OR:    ctrl = ALU_OR;
      F_ADD:   ctrl = ALU_ADD;
      F_SUB:   ctrl = ALU_SUB;
      F_SLT:   ctrl = ALU_SLT;
      F_NOR:   ctrl = ALU_NOR;
      F_MUL:   ctrl = ALU_MUL;
      F_SLL:   ctrl = ALU_SLL;
      F_SRL:   ctrl = ALU_SRL;
      F_XOR:   ctrl = ALU_XOR;
      F_SLTU:  ctrl = ALU_SLTU;
      F_SRA:   ctrl = ALU_SRA;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  // True when the funct appears in the decode table.
  function automatic logic funct_known(input logic [5:0] funct);
    logic known;
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_NOR,
      F_MUL, F_SLL, F_SRL, F_XOR, F_SLTU, F_SRA: known = 1'b1;
      default:                                   known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Rotating-priority picker: scans req_valid upward from ptr (mod NREQ) and
// returns a one-hot grant for the first set bit plus its index.
module alu_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // Walk the requesters in rotated order; the first valid one wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // NOTE: blocking assignments here are combinational temporaries that
      // must update within the same loop pass.
      j = IW'((int'(ptr) + i) % NREQ);
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Decodes funct to ALU control, holds the operands for a funct-dependent
// number of cycles, then returns the captured result on a valid/ready channel.
// Optional build macro ALU_ARB_FUNCT_CHECK_EN: unknown funct codes are
// answered immediately with resp_err=1 and a zero result instead of ADD.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N          = 16,
  parameter int NREQ       = 2,
  parameter int MUL_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [6*NREQ-1:0]       req_funct,
  input  logic [N*NREQ-1:0]       req_a,
  input  logic [N*NREQ-1:0]       req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [N-1:0]            resp_result,
  output logic                    resp_err,
  output logic [3:0]              alu_control,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  input  logic [N-1:0]            alu_result
);

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IW-1:0]    resp_id_q, resp_id_d;
  logic [N-1:0]     resp_result_q, resp_result_d;
  logic             resp_err_q, resp_err_d;
  logic [3:0]       alu_control_q, alu_control_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    pick_idx;
  logic [5:0]       sel_funct;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;

  alu_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (pick_idx)
  );

  // Route the winning requester's funct and operands using the one-hot grant.
  always_comb begin
    sel_funct = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_funct = req_funct[6*i +: 6];
        sel_a     = req_a[N*i +: N];
        sel_b     = req_b[N*i +: N];
      end
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    alu_control_d = alu_control_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    req_ready     = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) begin
          resp_id_d  = pick_idx;
          resp_err_d = 1'b0;
`ifdef ALU_ARB_FUNCT_CHECK_EN
          if (!funct_known(sel_funct)) begin
            // Illegal funct: answer at once, leave the ALU inputs untouched.
            resp_err_d    = 1'b1;
            resp_result_d = '0;
            resp_valid_d  = 1'b1;
            state_d       = ST_RESP;
          end else
`endif
          begin
            alu_control_d = funct_to_ctrl(sel_funct);
            alu_a_d       = sel_a;
            alu_b_d       = sel_b;
            cnt_d         = (sel_funct == F_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
            state_d       = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          resp_result_d = alu_result;
          resp_valid_d  = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = (resp_id_q == IW'(NREQ - 1)) ? '0 : resp_id_q + IW'(1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      alu_control_q <= ALU_ADD;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      alu_control_q <= alu_control_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign alu_control = alu_control_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (N=16, NREQ=2, MUL_CYCLES=3) with a
// behavioural ALU attached. Expectations follow ALU_ARB_FUNCT_CHECK_EN when
// the bench is built with that macro.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_result;
  logic        resp_err;
  logic [3:0]  alu_control;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  alu_arbiter #(.N(16), .NREQ(2), .MUL_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural combinational ALU the arbiter drives.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0011: alu_result = ~(alu_a | alu_b);
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1001: alu_result = alu_a * alu_b;
      4'b1010: alu_result = alu_a << alu_b[3:0];
      4'b1101: alu_result = alu_a >> alu_b[3:0];
      4'b1110: alu_result = {15'd0, alu_a < alu_b};
      4'b1111: alu_result = $signed(alu_a) >>> alu_b[3:0];
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [5:0] f, input logic [15:0] a,
                         input logic [15:0] b);
    req_funct[6*r +: 6]  = f;
    req_a[16*r +: 16]    = a;
    req_b[16*r +: 16]    = b;
  endtask

  // One transaction from requester r, resp_ready held high. Called and
  // returns just after a falling edge with the arbiter idle.
  task automatic do_txn(input string tag, input int r, input logic [5:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] exp_ctrl, input logic [15:0] exp_res,
                        input int exp_lat, input logic exp_err);
    int n;
    logic [1:0] exp_gnt;
    exp_gnt    = '0;
    exp_gnt[r] = 1'b1;
    set_req(r, f, a, b);
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".grant"}, 32'(req_ready), 32'(exp_gnt));
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 20);
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".id"}, 32'(resp_id), 32'(r));
    check({tag, ".result"}, 32'(resp_result), 32'(exp_res));
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".ctrl"}, 32'(alu_control), 32'(exp_ctrl));
    @(negedge clk);
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    int last_grant;
    logic seen;
    logic [15:0] held_res;

    rst        = 1'b1;
    req_valid  = '0;
    req_funct  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.resp_id", 32'(resp_id), 32'd0);
    check("rst.resp_result", 32'(resp_result), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.alu_control", 32'(alu_control), 32'h2);
    check("rst.alu_a", 32'(alu_a), 32'd0);
    check("rst.alu_b", 32'(alu_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD from req0: 3 + 5 = 8
    do_txn("add", 0, 6'b100000, 16'd3, 16'd5, 4'b0010, 16'd8, 2, 1'b0);
    // MUL from req1: 7 * 6 = 0x2A, resp_valid 1+MUL_CYCLES after grant
    do_txn("mul", 1, 6'b011000, 16'h0007, 16'h0006, 4'b1001, 16'h002A, 4, 1'b0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    set_req(0, 6'b100010, 16'd10, 16'd4);
    set_req(1, 6'b100101, 16'h00F0, 16'h000F);
    req_valid = 2'b11;
    #1;
    last_grant = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rr.grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) check("rr.spacing", 32'(cyc - last_grant), 32'd3);
      last_grant = cyc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (resp_valid !== 1'b1 && n < 20);
      check("rr.id", 32'(resp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      check("rr.result", 32'(resp_result), (k % 2 == 0) ? 32'd6 : 32'h00FF);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Back-pressure: req0 ADD 1+1 held in RESP for 5 cycles while req1 waits
    resp_ready = 1'b0;
    set_req(0, 6'b100000, 16'd1, 16'd1);
    req_valid[0] = 1'b1;
    #1;
    check("bp.grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    set_req(1, 6'b100110, 16'h00FF, 16'h0F0F);
    req_valid[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 20);
    check("bp.latency", 32'(n), 32'd2);
    held_res = resp_result;
    check("bp.result", 32'(held_res), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp.hold_valid", 32'(resp_valid), 32'd1);
      check("bp.hold_result", 32'(resp_result), 32'(held_res));
      check("bp.hold_id", 32'(resp_id), 32'd0);
      check("bp.no_grant", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("bp.hs_no_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp.after_hs_valid", 32'(resp_valid), 32'd0);
    check("bp.next_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 20);
    check("bp.xor_result", 32'(resp_result), 32'h0FF0);
    check("bp.xor_id", 32'(resp_id), 32'd1);
    @(negedge clk);

    // Illegal funct 111111 from req0, a=2 b=2
`ifdef ALU_ARB_FUNCT_CHECK_EN
    do_txn("illegal", 0, 6'b111111, 16'd2, 16'd2, 4'b0100, 16'd0, 1, 1'b1);
`else
    do_txn("illegal", 0, 6'b111111, 16'd2, 16'd2, 4'b0010, 16'd4, 2, 1'b0);
`endif

    // Reset pulsed mid-EXEC of a MUL from req1
    set_req(1, 6'b011000, 16'd3, 16'd3);
    req_valid[1] = 1'b1;
    #1;
    check("abort.grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.alu_control", 32'(alu_control), 32'h2);
    check("abort.alu_a", 32'(alu_a), 32'd0);
    check("abort.alu_b", 32'(alu_b), 32'd0);
    check("abort.resp_id", 32'(resp_id), 32'd0);
    check("abort.resp_result", 32'(resp_result), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check("abort.no_resp", 32'(seen), 32'd0);
    set_req(0, 6'b100000, 16'd100, 16'd23);
    set_req(1, 6'b100010, 16'd9, 16'd1);
    req_valid = 2'b11;
    #1;
    check("abort.ptr_zero", 32'(req_ready), 32'h1);
    req_valid[1] = 1'b0;
    do_txn("post_abort", 0, 6'b100000, 16'd100, 16'd23, 4'b0010, 16'd123, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
